// File: rtl/sema_pkg.sv
// Shared types and address packing for the semaphore bus initiator.
package sema_pkg;

    typedef enum logic [1:0] {
        SEMA_ACQUIRE = 2'b00,
        SEMA_RELEASE = 2'b01,
        SEMA_PEEK    = 2'b10,
        SEMA_SET     = 2'b11
    } sema_cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BUS,
        ST_GAP,
        ST_EVAL,
        ST_RESTORE,
        ST_GAP2,
        ST_BACKOFF,
        ST_WAIT,
        ST_DONE
    } sema_state_e;

    localparam int ADR_W    = 13;
    localparam int MODE_BIT = 12;
    localparam int IDX_MSB  = 11;
    localparam int IDX_LSB  = 4;
    localparam int AMT_MSB  = 3;
    localparam int AMT_LSB  = 0;

    // mode=1 selects absolute access, mode=0 counting access
    function automatic logic [ADR_W-1:0] sema_addr(input logic       mode,
                                                   input logic [7:0] idx,
                                                   input logic [3:0] amt);
        logic [ADR_W-1:0] a;
        a                    = '0;
        a[MODE_BIT]          = mode;
        a[IDX_MSB:IDX_LSB]   = idx;
        a[AMT_MSB:AMT_LSB]   = amt;
        return a;
    endfunction

endpackage

// File: rtl/sema_backoff.sv
// Loadable down-counter with terminal-count flag; times both the retry
// backoff wait and the bus acknowledge timeout.
module sema_backoff #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sema_master.sv
// Semaphore bus initiator: one command becomes slave bus cycles, with acquire
// retry/backoff/restore. Define SEMA_MASTER_ACK_TMO_EN for the ack timeout.
//
// state      | meaning
// IDLE       | waiting for a command
// BUS        | command access on the bus, waiting for ack
// GAP        | select low so the slave sees a fresh rising edge
// EVAL       | judge the read result
// RESTORE    | counting write giving back units a short acquire consumed
// GAP2       | select low after the restore write
// BACKOFF    | count down one retry
// WAIT       | idle backoff before re-issuing the acquire read
// DONE       | completion pulse; a new command may be accepted here
module sema_master
    import sema_pkg::*;
#(
    parameter int MAX_RETRY = 8,
    parameter int BACKOFF   = 16,
    parameter int ACK_TMO   = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [1:0]  cmd_i,
    input  logic [7:0]  sem_i,
    input  logic [3:0]  amt_i,
    input  logic [7:0]  val_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ok_o,
    output logic        err_o,
    output logic [7:0]  val_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [12:0] adr_o,
    output logic [7:0]  dat_o,
    input  logic        ack_i,
    input  logic [7:0]  dat_i
);

    localparam logic [7:0]  RETRY_LOAD = 8'(MAX_RETRY);
    localparam logic [15:0] BO_LOAD    = 16'(BACKOFF - 1);
    localparam logic [15:0] TMO_LOAD   = 16'(ACK_TMO - 1);

    sema_state_e state_q, state_d;
    sema_cmd_e   cmd_q;
    logic [7:0]  sem_q;
    logic [3:0]  amt_q;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  rd_q, rd_d;
    logic        ok_q, ok_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [12:0] adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic        accept;
    logic        tmr_load, tmr_done;
    logic [15:0] tmr_val;
`ifdef SEMA_MASTER_ACK_TMO_EN
    logic        err_q, err_d;
`endif

    assign accept = req_i && (state_q == ST_IDLE || state_q == ST_DONE);

    sema_backoff #(.W(16)) u_timer (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        rd_d     = rd_q;
        ok_d     = ok_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        tmr_load = 1'b0;
        tmr_val  = TMO_LOAD;
`ifdef SEMA_MASTER_ACK_TMO_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    we_d     = cmd_i[0];
                    adr_d    = sema_addr(cmd_i[1], sem_i, cmd_i[1] ? 4'h0 : amt_i);
                    dat_d    = (sema_cmd_e'(cmd_i) == SEMA_SET) ? val_i : 8'h00;
                    retry_d  = RETRY_LOAD;
                    ok_d     = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = ST_BUS;
`ifdef SEMA_MASTER_ACK_TMO_EN
                    err_d    = 1'b0;
`endif
                end
            end
            ST_BUS, ST_RESTORE: begin
                if (ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (!we_q) rd_d = dat_i;
                    state_d = (state_q == ST_BUS) ? ST_GAP : ST_GAP2;
                end
`ifdef SEMA_MASTER_ACK_TMO_EN
                else if (tmr_done) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_GAP: state_d = ST_EVAL;
            ST_EVAL: begin
                if (cmd_q != SEMA_ACQUIRE || rd_q >= {4'h0, amt_q}) begin
                    ok_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (rd_q == 8'h00) begin
                    state_d = ST_BACKOFF;
                end else begin
                    // slave saturated to 0 after consuming rd_q units; rd_q < 16 here
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    we_d     = 1'b1;
                    adr_d    = sema_addr(1'b0, sem_q, rd_q[3:0]);
                    dat_d    = 8'h00;
                    tmr_load = 1'b1;
                    state_d  = ST_RESTORE;
                end
            end
            ST_GAP2: state_d = ST_BACKOFF;
            ST_BACKOFF: begin
                retry_d = retry_q - 8'd1;
                if (retry_q <= 8'd1) begin
                    ok_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = BO_LOAD;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tmr_done) begin
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    we_d     = 1'b0;
                    adr_d    = sema_addr(1'b0, sem_q, amt_q);
                    dat_d    = 8'h00;
                    tmr_load = 1'b1;
                    state_d  = ST_BUS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cmd_q   <= SEMA_ACQUIRE;
            sem_q   <= 8'h00;
            amt_q   <= 4'h0;
            retry_q <= 8'h00;
            rd_q    <= 8'h00;
            ok_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= 8'h00;
`ifdef SEMA_MASTER_ACK_TMO_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            rd_q    <= rd_d;
            ok_q    <= ok_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
`ifdef SEMA_MASTER_ACK_TMO_EN
            err_q   <= err_d;
`endif
            if (accept) begin
                cmd_q <= sema_cmd_e'(cmd_i);
                sem_q <= sem_i;
                amt_q <= amt_i;
            end
        end
    end

    assign busy_o = !(state_q == ST_IDLE || state_q == ST_DONE);
    assign done_o = (state_q == ST_DONE);
    assign ok_o   = ok_q;
    assign val_o  = rd_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = stb_q;
    assign we_o   = we_q;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;
`ifdef SEMA_MASTER_ACK_TMO_EN
    assign err_o  = err_q;
`else
    assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sema_master.sv
// Directed bench for sema_master against a behavioural semaphore-memory slave.
module tb_sema_master;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_i  = 1'b0;
    logic [1:0]  cmd_i  = 2'b00;
    logic [7:0]  sem_i  = 8'h00;
    logic [3:0]  amt_i  = 4'h0;
    logic [7:0]  val_i  = 8'h00;
    logic        busy_o, done_o, ok_o, err_o;
    logic [7:0]  val_o;
    logic        cyc_o, stb_o, we_o;
    logic [12:0] adr_o;
    logic [7:0]  dat_o;
    logic        ack_i  = 1'b0;
    logic [7:0]  dat_i  = 8'h00;

    localparam logic [1:0] C_ACQ = 2'b00, C_REL = 2'b01, C_PEEK = 2'b10, C_SET = 2'b11;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    sema_master #(.MAX_RETRY(2), .BACKOFF(4), .ACK_TMO(8)) dut (
        .clk_i (clk_i),  .rst_ni(rst_ni), .req_i(req_i), .cmd_i(cmd_i),
        .sem_i (sem_i),  .amt_i (amt_i),  .val_i(val_i), .busy_o(busy_o),
        .done_o(done_o), .ok_o  (ok_o),   .err_o(err_o), .val_o (val_o),
        .cyc_o (cyc_o),  .stb_o (stb_o),  .we_o (we_o),  .adr_o (adr_o),
        .dat_o (dat_o),  .ack_i (ack_i),  .dat_i(dat_i)
    );

    // slave: acts once per rising select, zero-wait ack
    logic [7:0] mem [0:255];
    logic       ack_en  = 1'b1;
    logic       sl_busy = 1'b0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    always @(posedge clk_i) begin
        if (cyc_o && stb_o && !sl_busy && ack_en) begin
            sl_busy <= 1'b1;
            ack_i   <= 1'b1;
            if (adr_o[12]) begin
                if (we_o) mem[adr_o[11:4]] <= dat_o;
                else      dat_i <= mem[adr_o[11:4]];
            end else if (we_o) begin
                mem[adr_o[11:4]] <= (mem[adr_o[11:4]] > (8'hFF - {4'h0, adr_o[3:0]})) ?
                                    8'hFF : mem[adr_o[11:4]] + {4'h0, adr_o[3:0]};
            end else begin
                dat_i <= mem[adr_o[11:4]];
                mem[adr_o[11:4]] <= (mem[adr_o[11:4]] > {4'h0, adr_o[3:0]}) ?
                                    mem[adr_o[11:4]] - {4'h0, adr_o[3:0]} : 8'h00;
            end
        end else begin
            ack_i <= 1'b0;
            if (!cyc_o) sl_busy <= 1'b0;
        end
    end

    // access log: address/we/data of each acked access and idle cycles before it
    int          acc_total  = 0;
    int          done_total = 0;
    logic [12:0] acc_adr [0:255];
    logic        acc_we  [0:255];
    logic [7:0]  acc_dat [0:255];
    int          acc_gap [0:255];
    int          low_cnt  = 1000;
    int          pend_gap = 0;
    logic        prev_cyc = 1'b0;

    always @(negedge clk_i) begin
        if (cyc_o && !prev_cyc) pend_gap = low_cnt;
        if (cyc_o && ack_i) begin
            acc_adr[acc_total % 256] = adr_o;
            acc_we [acc_total % 256] = we_o;
            acc_dat[acc_total % 256] = dat_o;
            acc_gap[acc_total % 256] = pend_gap;
            acc_total++;
        end
        if (cyc_o) low_cnt = 0; else low_cnt++;
        prev_cyc = cyc_o;
        if (done_o) done_total++;
    end

    task automatic do_cmd(input logic [1:0] c, input logic [7:0] s, input logic [3:0] a,
                          input logic [7:0] v, output logic got_ok, output logic got_err,
                          output int nacc, output int first);
        bit seen = 0;
        @(negedge clk_i);
        first = acc_total;
        req_i = 1'b1; cmd_i = c; sem_i = s; amt_i = a; val_i = v;
        @(negedge clk_i);
        req_i = 1'b0;
        got_ok = 1'b0; got_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_o) begin
                seen = 1; got_ok = ok_o; got_err = err_o;
                break;
            end
            @(negedge clk_i);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL cmd_done_wait: cmd %0d sem %0h got no done_o within 300 cycles, required one", c, s);
        end
        nacc = acc_total - first;
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        tests++;
        if ({busy_o, done_o, ok_o, err_o, cyc_o, stb_o, we_o} !== 7'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b required 0000000",
                              {busy_o, done_o, ok_o, err_o, cyc_o, stb_o, we_o});
        end
        tests++;
        if ({val_o, adr_o, dat_o} !== 29'h0) begin
            fails++; $display("FAIL reset_data: val %h adr %h dat %h required 0", val_o, adr_o, dat_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        tests++;
        if (busy_o !== 1'b0) begin
            fails++; $display("FAIL reset_idle_busy: got %b required 0", busy_o);
        end
    endtask

    task automatic test_set_latency();
        bit seen = 0;
        @(negedge clk_i);
        req_i = 1'b1; cmd_i = C_SET; sem_i = 8'h05; amt_i = 4'h0; val_i = 8'h03;
        @(negedge clk_i);
        req_i = 1'b0;
        tests++;
        if ({busy_o, cyc_o, stb_o, we_o, adr_o, dat_o} !== {4'b1111, 13'h1050, 8'h03}) begin
            fails++; $display("FAIL set_issue: busy %b cyc %b stb %b we %b adr %h dat %h required 1 1 1 1 1050 03",
                              busy_o, cyc_o, stb_o, we_o, adr_o, dat_o);
        end
        tests++;
        if (ack_i !== 1'b0) begin
            fails++; $display("FAIL set_ack_early: ack %b required 0 one cycle after accept", ack_i);
        end
        @(negedge clk_i);
        tests++;
        if (ack_i !== 1'b1 || cyc_o !== 1'b1) begin
            fails++; $display("FAIL set_ack_latency: ack %b cyc %b required 1 1 two cycles after accept", ack_i, cyc_o);
        end
        for (int i = 0; i < 50; i++) begin
            if (done_o) begin seen = 1; break; end
            @(negedge clk_i);
        end
        tests++;
        if (!seen || ok_o !== 1'b1) begin
            fails++; $display("FAIL set_done: seen %0d ok %b required 1 1", seen, ok_o);
        end
        tests++;
        if (mem[5] !== 8'h03) begin
            fails++; $display("FAIL set_mem: got %h required 03", mem[5]);
        end
    endtask

    task automatic test_acquire_ok();
        logic o, e; int n, f;
        do_cmd(C_ACQ, 8'h05, 4'h1, 8'h00, o, e, n, f);
        tests++;
        if (o !== 1'b1 || n != 1 || acc_adr[f % 256] !== 13'h0051 || acc_we[f % 256] !== 1'b0) begin
            fails++; $display("FAIL acquire_bus: ok %b n %0d adr %h we %b required 1 1 0051 0",
                              o, n, acc_adr[f % 256], acc_we[f % 256]);
        end
        tests++;
        if (val_o !== 8'h03) begin
            fails++; $display("FAIL acquire_val: got %h required 03", val_o);
        end
        do_cmd(C_PEEK, 8'h05, 4'h0, 8'h00, o, e, n, f);
        tests++;
        if (val_o !== 8'h02 || acc_adr[f % 256] !== 13'h1050 || o !== 1'b1) begin
            fails++; $display("FAIL peek_after_acquire: val %h adr %h ok %b required 02 1050 1",
                              val_o, acc_adr[f % 256], o);
        end
    endtask

    task automatic test_retry_fail();
        logic o, e; int n, f;
        do_cmd(C_SET, 8'h05, 4'h0, 8'h00, o, e, n, f);
        do_cmd(C_ACQ, 8'h05, 4'h1, 8'h00, o, e, n, f);
        tests++;
        if (o !== 1'b0 || n != 2) begin
            fails++; $display("FAIL retry_result: ok %b accesses %0d required 0 2", o, n);
        end
        tests++;
        if (acc_gap[(f + 1) % 256] < 4 || acc_adr[(f + 1) % 256] !== 13'h0051) begin
            fails++; $display("FAIL retry_gap: gap %0d adr %h required >=4 0051",
                              acc_gap[(f + 1) % 256], acc_adr[(f + 1) % 256]);
        end
        tests++;
        if (mem[5] !== 8'h00 || val_o !== 8'h00) begin
            fails++; $display("FAIL retry_mem: mem %h val %h required 00 00", mem[5], val_o);
        end
    endtask

    task automatic test_restore();
        logic o, e; int n, f;
        do_cmd(C_SET, 8'h09, 4'h0, 8'h02, o, e, n, f);
        do_cmd(C_ACQ, 8'h09, 4'h3, 8'h00, o, e, n, f);
        tests++;
        if (n != 4 || acc_adr[f % 256] !== 13'h0093 || acc_we[f % 256] !== 1'b0) begin
            fails++; $display("FAIL restore_read: accesses %0d adr %h we %b required 4 0093 0",
                              n, acc_adr[f % 256], acc_we[f % 256]);
        end
        tests++;
        if (acc_adr[(f + 1) % 256] !== 13'h0092 || acc_we[(f + 1) % 256] !== 1'b1 ||
            acc_dat[(f + 1) % 256] !== 8'h00) begin
            fails++; $display("FAIL restore_write: adr %h we %b dat %h required 0092 1 00",
                              acc_adr[(f + 1) % 256], acc_we[(f + 1) % 256], acc_dat[(f + 1) % 256]);
        end
        tests++;
        if (o !== 1'b0 || val_o !== 8'h02 || mem[9] !== 8'h02) begin
            fails++; $display("FAIL restore_final: ok %b val %h mem %h required 0 02 02", o, val_o, mem[9]);
        end
    endtask

    task automatic test_release_sat();
        logic o, e; int n, f;
        do_cmd(C_SET, 8'h01, 4'h0, 8'hFE, o, e, n, f);
        do_cmd(C_REL, 8'h01, 4'h4, 8'h00, o, e, n, f);
        tests++;
        if (o !== 1'b1 || n != 1 || acc_adr[f % 256] !== 13'h0014 || acc_we[f % 256] !== 1'b1 ||
            acc_dat[f % 256] !== 8'h00) begin
            fails++; $display("FAIL release_bus: ok %b n %0d adr %h we %b dat %h required 1 1 0014 1 00",
                              o, n, acc_adr[f % 256], acc_we[f % 256], acc_dat[f % 256]);
        end
        do_cmd(C_PEEK, 8'h01, 4'h0, 8'h00, o, e, n, f);
        tests++;
        if (val_o !== 8'hFF) begin
            fails++; $display("FAIL release_saturate: got %h required ff", val_o);
        end
    endtask

    task automatic test_amt_zero();
        logic o, e; int n, f;
        do_cmd(C_ACQ, 8'h05, 4'h0, 8'h00, o, e, n, f);
        tests++;
        if (o !== 1'b1 || n != 1 || acc_adr[f % 256] !== 13'h0050 || mem[5] !== 8'h00) begin
            fails++; $display("FAIL acquire_zero: ok %b n %0d adr %h mem %h required 1 1 0050 00",
                              o, n, acc_adr[f % 256], mem[5]);
        end
    endtask

    task automatic test_busy_ignore();
        int f;
        bit seen = 0;
        @(negedge clk_i);
        f = acc_total;
        req_i = 1'b1; cmd_i = C_SET; sem_i = 8'h07; amt_i = 4'h0; val_i = 8'h42;
        @(negedge clk_i);
        cmd_i = C_PEEK; sem_i = 8'h03;
        repeat (2) @(negedge clk_i);
        req_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done_o) begin seen = 1; break; end
            @(negedge clk_i);
        end
        repeat (4) @(negedge clk_i);
        tests++;
        if (!seen || acc_total - f != 1 || acc_adr[f % 256] !== 13'h1070 || mem[7] !== 8'h42) begin
            fails++; $display("FAIL busy_ignore: done %0d accesses %0d adr %h mem %h required 1 1 1070 42",
                              seen, acc_total - f, acc_adr[f % 256], mem[7]);
        end
    endtask

    task automatic test_back_to_back();
        int f, d0, mingap;
        @(negedge clk_i);
        f = acc_total; d0 = done_total;
        req_i = 1'b1; cmd_i = C_PEEK; sem_i = 8'h01; amt_i = 4'h0;
        repeat (30) @(negedge clk_i);
        req_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy_o) break;
            @(negedge clk_i);
        end
        repeat (3) @(negedge clk_i);
        mingap = 1000;
        for (int i = f; i < acc_total; i++)
            if (acc_gap[i % 256] < mingap) mingap = acc_gap[i % 256];
        tests++;
        if (acc_total - f < 4 || acc_total - f != done_total - d0) begin
            fails++; $display("FAIL b2b_count: accesses %0d dones %0d required equal and >=4",
                              acc_total - f, done_total - d0);
        end
        tests++;
        if (mingap < 1 || val_o !== 8'hFF) begin
            fails++; $display("FAIL b2b_gap: min gap %0d val %h required >=1 ff", mingap, val_o);
        end
    endtask

`ifdef SEMA_MASTER_ACK_TMO_EN
    task automatic test_timeout();
        int hi = 0;
        bit seen = 0;
        ack_en = 1'b0;
        @(negedge clk_i);
        req_i = 1'b1; cmd_i = C_PEEK; sem_i = 8'h02;
        @(negedge clk_i);
        req_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_o) begin seen = 1; break; end
            if (cyc_o) hi++;
            @(negedge clk_i);
        end
        tests++;
        if (!seen || hi != 8 || err_o !== 1'b1 || ok_o !== 1'b0 || cyc_o !== 1'b0) begin
            fails++; $display("FAIL ack_timeout: done %0d cyc cycles %0d err %b ok %b cyc %b required 1 8 1 0 0",
                              seen, hi, err_o, ok_o, cyc_o);
        end
        ack_en = 1'b1;
    endtask
`endif

    task automatic test_reset_mid_bus();
        int d0;
        ack_en = 1'b0;
        @(negedge clk_i);
        req_i = 1'b1; cmd_i = C_SET; sem_i = 8'h04; val_i = 8'h77;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (cyc_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++; $display("FAIL mid_bus_setup: cyc %b busy %b required 1 1", cyc_o, busy_o);
        end
        d0 = done_total;
        #2 rst_ni = 1'b0;
        #1;
        tests++;
        if ({busy_o, done_o, ok_o, err_o, cyc_o, stb_o, we_o, val_o, adr_o, dat_o} !== 36'h0) begin
            fails++; $display("FAIL mid_bus_reset: busy %b cyc %b stb %b we %b adr %h dat %h val %h required all 0",
                              busy_o, cyc_o, stb_o, we_o, adr_o, dat_o, val_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        ack_en = 1'b1;
        repeat (6) @(negedge clk_i);
        tests++;
        if (done_total != d0 || busy_o !== 1'b0 || mem[4] !== 8'h00) begin
            fails++; $display("FAIL mid_bus_abandon: dones %0d busy %b mem %h required 0 0 00",
                              done_total - d0, busy_o, mem[4]);
        end
    endtask

    initial begin
        test_reset();
        test_set_latency();
        test_acquire_ok();
        test_retry_fail();
        test_restore();
        test_release_sat();
        test_amt_zero();
        test_busy_ignore();
        test_back_to_back();
`ifdef SEMA_MASTER_ACK_TMO_EN
        test_timeout();
`endif
        test_reset_mid_bus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
